uart_rx_parity_chk: RTL
=======================

// Module: uart_rx_parity_chk
// PURPOSE
//  UART receiver. Deserialises one asynchronous serial line into parallel words
//  and checks the optional parity bit against the configured even/odd sense.
//  Flags framing, parity and overrun errors.
//  Receive-side counterpart of the transmit path's parity generator; feeds the
//  RX data register / FIFO through a valid/ready handshake.
// PARAMETERS
//  DATA_BITS     8    data bits per frame (5..9), LSB received first
//  CLKS_PER_BIT  868  clk cycles per bit period (>=4); 868 = 100 MHz / 115200
// PORTS
//  clk            in   1          system clock, all logic on rising edge
//  rst            in   1          asynchronous, active-high reset
//  rx             in   1          serial input, idle high
//  parity_en      in   1          1: frame carries a parity bit after the data
//  parity_even_n  in   1          0: even parity, 1: odd parity
//  rx_data        out  DATA_BITS  received word, valid while rx_valid=1
//  rx_valid       out  1          word available
//  rx_ready       in   1          consumer accepts word when rx_valid & rx_ready
//  parity_err     out  1          qualifies rx_data: parity mismatch on this word
//  frame_err      out  1          qualifies rx_data: stop bit sampled low
//  overrun_err    out  1          1-cycle pulse: frame completed while rx_valid held
//  busy           out  1          1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset (async): FSM=IDLE; all outputs 0; rx_data=0; counters 0.
//  FSM states:
//   - IDLE:   rx=0 -> START, clear bit counter, baud counter=0.
//   - START:  at count CLKS_PER_BIT/2-1, resample rx.
//             rx=1 -> IDLE (glitch, no output).
//             rx=0 -> DATA; latch parity_en, parity_even_n for this frame.
//   - DATA:   sample every CLKS_PER_BIT cycles (bit mid-point); shift in LSB first.
//             After DATA_BITS samples -> PARITY if latched parity_en, else STOP.
//   - PARITY: sample received bit p. Expected bit = ^data XOR latched parity_even_n.
//             Mismatch sets internal perr. -> STOP.
//   - STOP:   sample; rx=0 sets internal ferr. -> IDLE.
//             Completion event fires the same cycle.
//  Completion:
//   - If rx_valid=0 or (rx_valid & rx_ready) that cycle: next cycle rx_data <=
//     word, parity_err <= perr, frame_err <= ferr, rx_valid <= 1.
//   - Else (word still pending, not accepted): new word dropped, pending word and
//     flags retained, overrun_err pulses 1 cycle.
//  Handshake: rx_valid, rx_data and flags are held stable until accepted.
//   Accept with no new completion -> rx_valid=0 next cycle.
//  Latency: rx_valid rises 1 clk after the stop-bit mid-sample (+2 with sync macro).
//  Parity/format inputs changing mid-frame: no effect until the next START.
//  Frame error: FSM still returns to IDLE. If rx stays low (break), IDLE sees
//   rx=0 and restarts; glitch filter rejects nothing while low, so a continuous
//   break yields repeated words of 0 with frame_err=1.
//  Reset mid-frame: frame discarded immediately; no rx_valid.
//  Baud counter width = $clog2(CLKS_PER_BIT); wraps to 0 at CLKS_PER_BIT-1.
// CONFIGURATION
//  UART_RX_SYNC_EN defined:
//   - rx passes through a 2-flop synchroniser (reset value 1) before the FSM.
//   - All latencies +2 clk.
//  UART_RX_SYNC_EN undefined:
//   - rx used directly; caller guarantees rx is already synchronous to clk.
// TESTING  (DATA_BITS=8, CLKS_PER_BIT=16, rx_ready=1 unless stated)
//  1. parity_en=0; send 0xA5, stop=1.
//     -> one rx_valid, rx_data=0xA5, parity_err=0, frame_err=0.
//  2. parity_en=1, parity_even_n=0; send 0x07 with p=1, then 0x07 with p=0.
//     -> parity_err=0, then parity_err=1; data 0x07 both times.
//  3. parity_en=1, parity_even_n=1; send 0x00 with p=1.
//     -> parity_err=0. Send 0x00 with p=0 -> parity_err=1.
//  4. Send 0x3C with stop bit 0.
//     -> rx_valid, rx_data=0x3C, frame_err=1; FSM returns to IDLE.
//  5. rx low for 4 clk only (glitch).
//     -> no rx_valid, busy drops back to 0, next frame 0x55 received correctly.
//  6. rx_ready=0; send 0x11 then 0x22.
//     -> rx_data stays 0x11; overrun_err pulses 1 clk at 2nd completion.
//     Then rx_ready=1 -> rx_valid=0 next clk.
//  Also: assert rst mid-DATA -> busy=0, no rx_valid. Rerun 1-6 with UART_RX_SYNC_EN.

Source files
------------

// File: rtl/uart_rx_parity_chk.sv
// uart_rx_parity_chk: UART receiver with optional even/odd parity check and framing/overrun flags.
// Build option UART_RX_SYNC_EN: put rx through a 2-flop synchroniser first (adds 2 clk latency).
module uart_rx_parity_chk #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_even_n,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic [BAUD_W-1:0]      r_baud;
  logic [BIT_W-1:0]       r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_en;
  logic                   r_par_odd;
  logic                   r_perr;

  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic                   w_rx;
  logic                   w_half_tick;
  logic                   w_baud_tick;
  logic                   w_complete;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Idle-high reset value keeps the FSM from seeing a false start bit out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rx};
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = rx;
`endif

  assign w_half_tick = (r_baud == HALF_LAST);
  assign w_baud_tick = (r_baud == BAUD_LAST);
  assign w_complete  = (r_state == S_STOP) && w_baud_tick;

  // Frame FSM: start-bit qualification at half a bit, then mid-bit sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
          end
        end

        S_START: begin
          if (w_half_tick) begin
            r_baud <= '0;
            if (w_rx) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_par_en  <= parity_en;
              r_par_odd <= parity_even_n;
              r_perr    <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end

        S_DATA: begin
          if (w_baud_tick) begin
            r_baud  <= '0;
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_bit   <= r_bit + BIT_ONE;
            if (r_bit == BIT_LAST) r_state <= r_par_en ? S_PARITY : S_STOP;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end

        S_PARITY: begin
          if (w_baud_tick) begin
            r_baud  <= '0;
            r_perr  <= w_rx ^ (^r_shift) ^ r_par_odd;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end

        S_STOP: begin
          if (w_baud_tick) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register: a pending unaccepted word wins over a newly completed one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data    <= r_shift;
          r_parity_err <= r_perr;
          r_frame_err  <= ~w_rx;
          r_rx_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;
  assign busy        = r_busy;

endmodule
